carfield_domain_seq: RTL and testbench

Parametrised clock-enable and reset sequencer for N Carfield clock domains. It generalises the fixed host/periph/alt domain set to NumDomains. Each domain is brought up and down under a shared PLL lock: wait for lock, ungate the clock with reset held, then release reset. On shutdown it asserts reset before gating the clock. It sits between the PLL/clock-gating cells and the per-domain reset trees of the chip top.

---
 rtl/carfield_domain_seq_pkg.sv | 27 ++
 rtl/carfield_domain_seq_fsm.sv | 127 ++++++++++++
 rtl/carfield_domain_seq.sv | 48 ++++
 tb/tb_carfield_domain_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/carfield_domain_seq_pkg.sv
// Shared types and defaults for the Carfield clock-domain sequencer.
package carfield_domain_seq_pkg;

   typedef enum logic [2:0] {
      OFF       = 3'd0,
      WAIT_LOCK = 3'd1,
      CLK_ON    = 3'd2,
      RUN       = 3'd3,
      DRAIN     = 3'd4,
      ERR       = 3'd5
   } domain_state_e;

   localparam int unsigned DefaultLockTimeout   = 1024;
   localparam int unsigned DefaultRstHoldCycles = 4;

   // Domain index d of the en_i/clk_en_o/... vectors.
   typedef enum int unsigned {
      HostDomainClkIdx   = 0,
      PeriphDomainClkIdx = 1,
      AltDomainClkIdx    = 2
   } domain_idx_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/carfield_domain_seq_fsm.sv
// Single-domain power sequencer: lock wait, clock-on with reset held, run,
// and reset-before-gate drain. Outputs are decoded from the state register.
module carfield_domain_fsm
   import carfield_domain_seq_pkg::*;
#(
   parameter int unsigned LockTimeout   = DefaultLockTimeout,
   parameter int unsigned RstHoldCycles = DefaultRstHoldCycles
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pll_lock_i,
   input  logic en_i,
   output logic clk_en_o,
   output logic rst_no,
   output logic ready_o,
   output logic err_o,
   output logic lock_lost_o,
   output logic busy_o
);

   localparam int unsigned CntWidth = $clog2(max_u(LockTimeout, RstHoldCycles)) + 1;
   localparam logic [CntWidth-1:0] LockLast = CntWidth'(LockTimeout - 1);
   localparam logic [CntWidth-1:0] HoldLast = CntWidth'(RstHoldCycles - 1);
   localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

   domain_state_e       state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                lost_q, lost_d;

   // Next-state and counter logic; lock loss beats enable drop beats counter expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lost_d  = 1'b0;
      unique case (state_q)
         OFF: begin
            if (en_i) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         WAIT_LOCK: begin
            if (!en_i) begin
               state_d = OFF;
               cnt_d   = '0;
            end else if (pll_lock_i) begin
               state_d = CLK_ON;
               cnt_d   = '0;
            end else if (cnt_q == LockLast) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         CLK_ON: begin
            if (!pll_lock_i) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               lost_d  = 1'b1;
            end else if (!en_i) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else if (cnt_q == HoldLast) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         RUN: begin
            if (!pll_lock_i) begin
               state_d = en_i ? WAIT_LOCK : OFF;
               cnt_d   = '0;
               lost_d  = 1'b1;
            end else if (!en_i) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            // A re-asserted enable is ignored here; the domain restarts from OFF.
            if (!pll_lock_i) begin
               state_d = OFF;
               cnt_d   = '0;
               lost_d  = 1'b1;
            end else if (cnt_q == HoldLast) begin
               state_d = OFF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         ERR: begin
            // Only withdrawing the enable clears a timeout; lock return does not.
            if (!en_i) begin
               state_d = OFF;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = OFF;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and lock-lost pulse registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= OFF;
         cnt_q   <= '0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lost_q  <= lost_d;
      end
   end

   assign clk_en_o    = (state_q == CLK_ON) || (state_q == RUN) || (state_q == DRAIN);
   assign rst_no      = (state_q == RUN);
   assign ready_o     = (state_q == RUN);
   assign err_o       = (state_q == ERR);
   assign lock_lost_o = lost_q;
   assign busy_o      = (state_q == WAIT_LOCK) || (state_q == CLK_ON) || (state_q == DRAIN);

endmodule

// File: rtl/carfield_domain_seq.sv
// Clock-enable / reset sequencer for NumDomains independent Carfield domains
// sharing one PLL lock.
module carfield_domain_seq
   import carfield_domain_seq_pkg::*;
#(
   parameter int unsigned NumDomains    = 3,
   parameter int unsigned LockTimeout   = DefaultLockTimeout,
   parameter int unsigned RstHoldCycles = DefaultRstHoldCycles
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  pll_lock_i,
   input  logic [NumDomains-1:0] en_i,
   output logic [NumDomains-1:0] clk_en_o,
   output logic [NumDomains-1:0] rst_no,
   output logic [NumDomains-1:0] ready_o,
   output logic [NumDomains-1:0] err_o,
   output logic [NumDomains-1:0] lock_lost_o,
   output logic                  busy_o
);

   logic [NumDomains-1:0] busy;

   for (genvar d = 0; d < NumDomains; d++) begin : g_domain
      carfield_domain_fsm #(
         .LockTimeout   (LockTimeout),
         .RstHoldCycles (RstHoldCycles)
      ) i_fsm (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .pll_lock_i  (pll_lock_i),
         .en_i        (en_i[d]),
         .clk_en_o    (clk_en_o[d]),
         .rst_no      (rst_no[d]),
         .ready_o     (ready_o[d]),
         .err_o       (err_o[d]),
         .lock_lost_o (lock_lost_o[d]),
         .busy_o      (busy[d])
      );

      // A domain must never leave reset without its clock running.
      a_rst_needs_clk : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                         rst_no[d] |-> clk_en_o[d]);
   end

   assign busy_o = |busy;

endmodule

// File: tb/tb_carfield_domain_seq.sv
// Bench for carfield_domain_seq: vector table, directed corner sequences and
// a randomised run against a phase/timer reference model.
module tb_carfield_domain_seq;

   localparam int ND = 3;
   localparam int LT = 16;
   localparam int RH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          lock;
   logic [ND-1:0] en;
   logic [ND-1:0] clk_en, rst_o, ready, err, ll;
   logic          busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   carfield_domain_seq #(
      .NumDomains    (ND),
      .LockTimeout   (LT),
      .RstHoldCycles (RH)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .pll_lock_i  (lock),
      .en_i        (en),
      .clk_en_o    (clk_en),
      .rst_no      (rst_o),
      .ready_o     (ready),
      .err_o       (err),
      .lock_lost_o (ll),
      .busy_o      (busy)
   );

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic [2:0] ce, input logic [2:0] rs,
                          input logic [2:0] rd, input logic [2:0] er, input logic [2:0] lo,
                          input logic bz);
      chk({tag, ".clk_en"}, clk_en, ce);
      chk({tag, ".rst_n"}, rst_o, rs);
      chk({tag, ".ready"}, ready, rd);
      chk({tag, ".err"}, err, er);
      chk({tag, ".lock_lost"}, ll, lo);
      chk({tag, ".busy"}, {2'b00, busy}, {2'b00, bz});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en    = '0;
      step();
      rst_n = 1'b1;
   endtask

   // ---------------- reference model ----------------
   // Phases: idle, awaiting lock, clocked in reset, live, draining, faulted.
   // m_t counts cycles already spent in the current phase (1 on entry).
   localparam int P_IDLE = 0, P_WAIT = 1, P_HOLD = 2, P_LIVE = 3, P_DRAIN = 4, P_FAULT = 5;
   int            m_ph [ND];
   int            m_t  [ND];
   logic [ND-1:0] m_ll;

   task automatic enter(input int d, input int ph);
      m_ph[d] = ph;
      m_t[d]  = 1;
   endtask

   task automatic model_step(input logic r, input logic lk, input logic [ND-1:0] e);
      m_ll = '0;
      for (int d = 0; d < ND; d++) begin
         if (!r) begin
            m_ph[d] = P_IDLE;
            m_t[d]  = 0;
         end else begin
            case (m_ph[d])
               P_IDLE:  if (e[d]) enter(d, P_WAIT);
               P_WAIT: begin
                  if (!e[d]) enter(d, P_IDLE);
                  else if (lk) enter(d, P_HOLD);
                  else if (m_t[d] == LT) enter(d, P_FAULT);
                  else m_t[d]++;
               end
               P_HOLD: begin
                  if (!lk) begin enter(d, P_WAIT); m_ll[d] = 1'b1; end
                  else if (!e[d]) enter(d, P_DRAIN);
                  else if (m_t[d] == RH) enter(d, P_LIVE);
                  else m_t[d]++;
               end
               P_LIVE: begin
                  if (!lk) begin enter(d, e[d] ? P_WAIT : P_IDLE); m_ll[d] = 1'b1; end
                  else if (!e[d]) enter(d, P_DRAIN);
               end
               P_DRAIN: begin
                  if (!lk) begin enter(d, P_IDLE); m_ll[d] = 1'b1; end
                  else if (m_t[d] == RH) enter(d, P_IDLE);
                  else m_t[d]++;
               end
               default: if (!e[d]) enter(d, P_IDLE);
            endcase
         end
      end
   endtask

   task automatic model_check(input string tag);
      logic [ND-1:0] ce, rs, er;
      logic          bz;
      ce = '0; rs = '0; er = '0; bz = 1'b0;
      for (int d = 0; d < ND; d++) begin
         ce[d] = (m_ph[d] == P_HOLD) || (m_ph[d] == P_LIVE) || (m_ph[d] == P_DRAIN);
         rs[d] = (m_ph[d] == P_LIVE);
         er[d] = (m_ph[d] == P_FAULT);
         if ((m_ph[d] == P_WAIT) || (m_ph[d] == P_HOLD) || (m_ph[d] == P_DRAIN)) bz = 1'b1;
      end
      chk_all(tag, ce, rs, rs, er, m_ll, bz);
      chk({tag, ".rst_implies_clk"}, rst_o & ~clk_en, 3'b000);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst_n;
      logic       lock;
      logic [2:0] en;
      logic [2:0] ce, rs, rd, er, lo;
      logic       bz;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int low_len;

      rst_n = 1'b0;
      lock  = 1'b0;
      en    = '0;

      // power-up on domain 0, then lock drop together with enable drop
      tbl[0] = '{1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0};
      tbl[8] = '{1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};

      for (int i = 0; i < 9; i++) begin
         rst_n = tbl[i].rst_n;
         lock  = tbl[i].lock;
         en    = tbl[i].en;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].ce, tbl[i].rs, tbl[i].rd, tbl[i].er,
                 tbl[i].lo, tbl[i].bz);
      end

      // lock timeout on domain 1, sticky error, cleared by enable drop
      do_reset();
      lock = 1'b0;
      en   = 3'b010;
      step();
      chk("timeout.busy", {2'b00, busy}, 3'b001);
      for (int i = 1; i < LT; i++) begin
         step();
         chk($sformatf("timeout.err_early%0d", i), err, 3'b000);
      end
      step();
      chk("timeout.err_set", err, 3'b010);
      chk("timeout.busy_err", {2'b00, busy}, 3'b000);
      lock = 1'b1;
      repeat (3) step();
      chk("timeout.err_sticky", err, 3'b010);
      chk("timeout.clk_gated", clk_en, 3'b000);
      en = 3'b000;
      step();
      chk("timeout.err_clr", err, 3'b000);
      chk("timeout.off", clk_en, 3'b000);

      // lock loss in RUN on all domains, then re-sequence
      do_reset();
      lock = 1'b1;
      en   = 3'b111;
      repeat (1 + RH + 1) step();
      chk("lost.ready_all", ready, 3'b111);
      lock = 1'b0;
      step();
      chk("lost.clk_en", clk_en, 3'b000);
      chk("lost.rst_n", rst_o, 3'b000);
      chk("lost.pulse", ll, 3'b111);
      step();
      chk("lost.pulse_end", ll, 3'b000);
      chk("lost.busy", {2'b00, busy}, 3'b001);
      lock = 1'b1;
      step();
      chk("relock.clk_en", clk_en, 3'b111);
      chk("relock.rst_held", rst_o, 3'b000);
      repeat (RH - 1) begin
         step();
         chk("relock.rst_hold", rst_o, 3'b000);
      end
      step();
      chk("relock.rst_rel", rst_o, 3'b111);
      chk("relock.ready", ready, 3'b111);

      // shutdown of domain 2 with enable re-asserted mid-drain
      en = 3'b011;
      step();
      chk("drain.rst_n", rst_o, 3'b011);
      chk("drain.clk_en0", clk_en, 3'b111);
      step();
      chk("drain.clk_en1", clk_en, 3'b111);
      en = 3'b111;
      step();
      chk("drain.clk_en2", clk_en, 3'b111);
      chk("drain.ignore_en", rst_o, 3'b011);
      step();
      chk("drain.clk_en3", clk_en, 3'b111);
      step();
      chk("drain.off", clk_en, 3'b011);
      chk("drain.busy_off", {2'b00, busy}, 3'b000);
      step();
      chk("drain.restart_wait", {2'b00, busy}, 3'b001);
      chk("drain.restart_gated", clk_en, 3'b011);
      step();
      chk("drain.restart_clk", clk_en, 3'b111);
      chk("drain.restart_rst", rst_o, 3'b011);

      // reset taken while domain 2 sits in CLK_ON
      rst_n = 1'b0;
      step();
      chk_all("midreset", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      rst_n = 1'b1;
      en    = 3'b000;

      // randomised run against the reference model
      rst_n = 1'b0;
      step();
      model_step(1'b0, lock, en);
      model_check("rand_init");
      rst_n   = 1'b1;
      lock    = 1'b1;
      low_len = 0;
      for (int c = 0; c < 3000; c++) begin
         if (lock) begin
            if ($urandom_range(0, 39) == 0) begin
               lock    = 1'b0;
               low_len = int'($urandom_range(1, 30));
            end
         end else begin
            low_len--;
            if (low_len <= 0) lock = 1'b1;
         end
         for (int d = 0; d < ND; d++)
            if ($urandom_range(0, 15) == 0) en[d] = ~en[d];
         rst_n = ($urandom_range(0, 499) != 0);
         step();
         model_step(rst_n, lock, en);
         model_check($sformatf("rand%0d", c));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
